intr_ctrl: RTL and testbench

Memory-mapped interrupt controller between the system bridge's 6-bit interrupt request bus and the processor's exception logic.
- Latches device interrupt lines, applying per-source trigger mode and mask, and presents one prioritised request with a vector to the CPU.
- Tracks the in-service source until software writes end-of-interrupt (EOI).
- Sits as a third bridge device at word-aligned offsets 0x0–0xC of its decoded window.

---
 rtl/intr_pkg.sv | 23 ++
 rtl/intr_prio_enc.sv | 24 ++
 rtl/intr_ctrl.sv | 150 +++++++++++++++
 tb/tb_intr_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register
// offsets within the bridge window and STAT field layout.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] OFS_PEND = 2'd0;
    localparam logic [1:0] OFS_MASK = 2'd1;
    localparam logic [1:0] OFS_TRIG = 2'd2;
    localparam logic [1:0] OFS_STAT = 2'd3;

    // STAT layout: insvc occupies [vec_w-1:0], busy sits directly above it
    localparam int STAT_INSVC_LSB = 0;

    function automatic int stat_busy_bit(input int vec_w);
        return STAT_INSVC_LSB + vec_w;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req_i and whether
// any request bit is set at all.
module intr_prio_enc #(
    parameter int N_IRQ = 6,
    parameter int VEC_W = 3
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [VEC_W-1:0] idx_o,
    output logic             vld_o
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        idx_o = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = VEC_W'(i);
            end
        end
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: per-source edge/level pending, mask,
// one prioritised request to the CPU and in-service tracking until EOI.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_IRQ = 6,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] iIRQ,
    input  logic [1:0]       iAddr,
    input  logic [31:0]      iWData,
    input  logic             iWE,
    output logic [31:0]      oRData,
    output logic             oIRQ,
    output logic [VEC_W-1:0] oVector,
    input  logic             iAck
);

    localparam int BUSY_BIT = stat_busy_bit(VEC_W);

    state_e             state_q, state_d;
    logic [N_IRQ-1:0]   prev_q;
    logic [N_IRQ-1:0]   edge_q, edge_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [N_IRQ-1:0]   trig_q, trig_d;
    logic [VEC_W-1:0]   insvc_q, insvc_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               irq_q, irq_d;

    logic [N_IRQ-1:0]   pend_eff;
    logic [N_IRQ-1:0]   req;
    logic [N_IRQ-1:0]   w1c;
    logic [N_IRQ-1:0]   ack_clr;
    logic [VEC_W-1:0]   sel;
    logic               any_req;
    logic               wr_pend, wr_mask, wr_trig, wr_stat;
    logic               busy;
    logic               unused_wdata_hi;

    assign wr_pend = iWE && (iAddr == OFS_PEND);
    assign wr_mask = iWE && (iAddr == OFS_MASK);
    assign wr_trig = iWE && (iAddr == OFS_TRIG);
    assign wr_stat = iWE && (iAddr == OFS_STAT);

    // Only the low N_IRQ bits of a write carry register content
    assign unused_wdata_hi = ^iWData[31:N_IRQ];

    // Edge sources read their sticky bit, level sources read the live line
    assign pend_eff = (trig_q & edge_q) | (~trig_q & iIRQ);
    assign req      = pend_eff & mask_q;
    assign busy     = (state_q == ST_SERVICE);

    intr_prio_enc #(
        .N_IRQ (N_IRQ),
        .VEC_W (VEC_W)
    ) u_prio (
        .req_i (req),
        .idx_o (sel),
        .vld_o (any_req)
    );

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        insvc_d = insvc_q;
        ack_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_REQ;
                    irq_d   = 1'b1;
                    vec_d   = sel;
                end
            end
            ST_REQ: begin
                // An acknowledge refers to the vector the CPU saw, so it
                // takes precedence over the request disappearing.
                if (iAck) begin
                    insvc_d = vec_q;
                    ack_clr = N_IRQ'(1) << vec_q;
                    irq_d   = 1'b0;
                    state_d = ST_SERVICE;
                end else if (!any_req) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    vec_d   = sel;
                end
            end
            ST_SERVICE: begin
                if (wr_stat) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // A new rising edge overrides any clear arriving in the same cycle
    assign w1c    = wr_pend ? iWData[N_IRQ-1:0] : '0;
    assign edge_d = ((edge_q & ~w1c & ~ack_clr) | (iIRQ & ~prev_q)) & trig_q;
    assign mask_d = wr_mask ? iWData[N_IRQ-1:0] : mask_q;
    assign trig_d = wr_trig ? iWData[N_IRQ-1:0] : trig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            trig_q  <= '0;
            insvc_q <= '0;
            vec_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= iIRQ;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            trig_q  <= trig_d;
            insvc_q <= insvc_d;
            vec_q   <= vec_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        oRData = '0;
        unique case (iAddr)
            OFS_PEND: oRData[N_IRQ-1:0] = pend_eff;
            OFS_MASK: oRData[N_IRQ-1:0] = mask_q;
            OFS_TRIG: oRData[N_IRQ-1:0] = trig_q;
            OFS_STAT: begin
                oRData[STAT_INSVC_LSB +: VEC_W] = insvc_q;
                oRData[BUSY_BIT]                = busy;
            end
            default:  oRData = '0;
        endcase
    end

    assign oIRQ    = irq_q;
    assign oVector = vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed vector table, hand-written
// reset sequence, then randomized traffic against a behavioural model.
module tb_intr_ctrl;

    localparam int N_IRQ = 6;
    localparam int VEC_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_IRQ-1:0] iIRQ;
    logic [1:0]       iAddr;
    logic [31:0]      iWData;
    logic             iWE;
    logic [31:0]      oRData;
    logic             oIRQ;
    logic [VEC_W-1:0] oVector;
    logic             iAck;

    always #5 clk = ~clk;

    intr_ctrl #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .iIRQ    (iIRQ),
        .iAddr   (iAddr),
        .iWData  (iWData),
        .iWE     (iWE),
        .oRData  (oRData),
        .oIRQ    (oIRQ),
        .oVector (oVector),
        .iAck    (iAck)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: request/service described as two flags
    bit [5:0] m_edge, m_mask, m_trig, m_prev;
    bit       m_irq, m_busy;
    int       m_vec;
    bit [2:0] m_insvc;

    function automatic bit [5:0] m_pend(input bit [5:0] live);
        bit [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = m_trig[i] ? m_edge[i] : live[i];
        return p;
    endfunction

    function automatic int lowest(input bit [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [31:0] m_read(input bit [1:0] a, input bit [5:0] live);
        case (a)
            2'd0:    return 32'(m_pend(live));
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_trig);
            default: return 32'({m_busy, m_insvc});
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit [5:0] irq, input bit we,
                              input bit [1:0] a, input bit [31:0] wd, input bit ack);
        bit [5:0] req, nedge;
        int       sel;
        bit       acc;
        if (rst) begin
            m_edge = '0; m_mask = '0; m_trig = '0; m_prev = '0;
            m_irq = 0; m_busy = 0; m_vec = 0; m_insvc = '0;
            return;
        end
        req = m_pend(irq) & m_mask;
        sel = lowest(req);
        acc = m_irq && ack;
        for (int i = 0; i < 6; i++) begin
            bit keep, rise;
            keep = m_edge[i] && !(we && a == 2'd0 && wd[i]) && !(acc && m_vec == i);
            rise = irq[i] && !m_prev[i];
            nedge[i] = m_trig[i] && (keep || rise);
        end
        if (m_irq) begin
            if (ack) begin
                m_insvc = 3'(m_vec);
                m_irq   = 0;
                m_busy  = 1;
            end else if (sel < 0) begin
                m_irq = 0;
            end else begin
                m_vec = sel;
            end
        end else if (m_busy) begin
            if (we && a == 2'd3) m_busy = 0;
        end else if (sel >= 0) begin
            m_irq = 1;
            m_vec = sel;
        end
        if (we && a == 2'd1) m_mask = wd[5:0];
        if (we && a == 2'd2) m_trig = wd[5:0];
        m_edge = nedge;
        m_prev = irq;
    endtask

    // Drive one cycle of inputs, advance the model and the DUT by one edge
    task automatic step(input bit rst, input bit [5:0] irq, input bit we,
                        input bit [1:0] a, input bit [31:0] wd, input bit ack);
        reset = rst; iIRQ = irq; iWE = we; iAddr = a; iWData = wd; iAck = ack;
        model_edge(rst, irq, we, a, wd, ack);
        @(posedge clk);
        #1;
        reset = 1'b0; iWE = 1'b0; iAck = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        iAddr = a;
        #1;
        d = oRData;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [5:0]  irq;
        logic        ack;
        logic        eirq;
        logic [2:0]  evec;
        logic [1:0]  raddr;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                                input logic [5:0] irq, input logic ack, input logic eirq,
                                input logic [2:0] evec, input logic [1:0] raddr,
                                input logic [31:0] erd);
        vec_t v;
        v.we = we; v.addr = addr; v.wd = wd; v.irq = irq; v.ack = ack;
        v.eirq = eirq; v.evec = evec; v.raddr = raddr; v.erd = erd;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        logic [31:0] d;
        reset = 1'b1; iIRQ = '0; iAddr = '0; iWData = '0; iWE = 1'b0; iAck = 1'b0;
        #1;
        step(1, 6'h00, 0, 2'd0, 0, 0);
        step(1, 6'h00, 0, 2'd0, 0, 0);

        check("rst_irq", 32'(oIRQ), 32'h0);
        check("rst_vec", 32'(oVector), 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("rst_rd%0d", a), d, 32'h0);
        end
        // Level mode after reset: PEND mirrors the live lines
        iIRQ = 6'h15;
        rd(2'd0, d);
        check("rst_pend_live", d, 32'h15);
        iIRQ = 6'h00;
        #1;

        //            we addr  wd       irq    ack eirq vec raddr erd
        tbl[0]  = mk(1, 2'd1, 32'h3F, 6'h00, 0, 0, 0, 2'd1, 32'h3F);
        tbl[1]  = mk(1, 2'd2, 32'h3F, 6'h00, 0, 0, 0, 2'd2, 32'h3F);
        tbl[2]  = mk(0, 2'd0, 32'h00, 6'h10, 0, 0, 0, 2'd0, 32'h10);
        tbl[3]  = mk(0, 2'd0, 32'h00, 6'h00, 0, 1, 4, 2'd0, 32'h10);
        tbl[4]  = mk(0, 2'd0, 32'h00, 6'h00, 1, 0, 0, 2'd3, 32'h0C);
        tbl[5]  = mk(1, 2'd3, 32'h00, 6'h00, 0, 0, 0, 2'd3, 32'h04);
        tbl[6]  = mk(0, 2'd0, 32'h00, 6'h24, 0, 0, 0, 2'd0, 32'h24);
        tbl[7]  = mk(0, 2'd0, 32'h00, 6'h00, 0, 1, 2, 2'd0, 32'h24);
        tbl[8]  = mk(0, 2'd0, 32'h00, 6'h00, 1, 0, 0, 2'd0, 32'h20);
        tbl[9]  = mk(0, 2'd0, 32'h00, 6'h00, 0, 0, 0, 2'd3, 32'h0A);
        tbl[10] = mk(1, 2'd3, 32'h00, 6'h00, 0, 0, 0, 2'd3, 32'h02);
        tbl[11] = mk(0, 2'd0, 32'h00, 6'h00, 0, 1, 5, 2'd3, 32'h02);
        tbl[12] = mk(0, 2'd0, 32'h00, 6'h00, 1, 0, 0, 2'd0, 32'h00);
        tbl[13] = mk(1, 2'd3, 32'h00, 6'h00, 0, 0, 0, 2'd3, 32'h05);
        tbl[14] = mk(1, 2'd2, 32'h3D, 6'h00, 0, 0, 0, 2'd2, 32'h3D);
        tbl[15] = mk(1, 2'd1, 32'h02, 6'h00, 0, 0, 0, 2'd1, 32'h02);
        tbl[16] = mk(0, 2'd0, 32'h00, 6'h02, 0, 1, 1, 2'd0, 32'h02);
        tbl[17] = mk(1, 2'd0, 32'h02, 6'h02, 0, 1, 1, 2'd0, 32'h02);
        tbl[18] = mk(0, 2'd0, 32'h00, 6'h00, 0, 0, 0, 2'd3, 32'h05);
        tbl[19] = mk(1, 2'd1, 32'h08, 6'h00, 0, 0, 0, 2'd1, 32'h08);
        tbl[20] = mk(0, 2'd0, 32'h00, 6'h08, 0, 0, 0, 2'd0, 32'h08);
        tbl[21] = mk(0, 2'd0, 32'h00, 6'h00, 0, 1, 3, 2'd0, 32'h08);
        tbl[22] = mk(1, 2'd1, 32'h00, 6'h00, 0, 1, 3, 2'd1, 32'h00);
        tbl[23] = mk(0, 2'd0, 32'h00, 6'h00, 0, 0, 0, 2'd3, 32'h05);
        tbl[24] = mk(0, 2'd0, 32'h00, 6'h00, 1, 0, 0, 2'd3, 32'h05);
        tbl[25] = mk(1, 2'd1, 32'h01, 6'h00, 0, 0, 0, 2'd0, 32'h08);
        tbl[26] = mk(1, 2'd0, 32'h01, 6'h01, 0, 0, 0, 2'd0, 32'h09);
        tbl[27] = mk(0, 2'd0, 32'h00, 6'h00, 0, 1, 0, 2'd0, 32'h09);
        tbl[28] = mk(1, 2'd0, 32'h01, 6'h00, 1, 0, 0, 2'd3, 32'h08);

        for (int i = 0; i < 29; i++) begin
            step(0, tbl[i].irq, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].ack);
            check($sformatf("row%0d_irq", i), 32'(oIRQ), 32'(tbl[i].eirq));
            if (tbl[i].eirq) check($sformatf("row%0d_vec", i), 32'(oVector), 32'(tbl[i].evec));
            rd(tbl[i].raddr, d);
            check($sformatf("row%0d_rd", i), d, tbl[i].erd);
        end

        // Reset while in service, with a pending edge bit and mask set
        step(0, 6'h04, 0, 2'd0, 0, 0);
        step(1, 6'h00, 0, 2'd0, 0, 0);
        check("svc_rst_irq", 32'(oIRQ), 32'h0);
        check("svc_rst_vec", 32'(oVector), 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("svc_rst_rd%0d", a), d, 32'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            bit [31:0] r;
            bit [5:0]  nirq;
            bit        we, ack, rst;
            bit [1:0]  a, ra;
            r    = $urandom & $urandom & $urandom;
            nirq = iIRQ ^ r[5:0];
            we   = ($urandom_range(0, 3) == 0);
            a    = 2'($urandom_range(0, 3));
            ack  = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            step(rst, nirq, we, a, $urandom, ack);
            check("rnd_irq", 32'(oIRQ), 32'(m_irq));
            if (m_irq) check("rnd_vec", 32'(oVector), 32'(m_vec));
            ra = 2'($urandom_range(0, 3));
            rd(ra, d);
            check($sformatf("rnd_rd%0d", ra), d, m_read(ra, iIRQ));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
